// File: rtl/apb_master_engine_if.sv
// Command/response port and APB bus bundle for apb_master_engine.
// The master modport is the engine's view; the slave modport is the environment's view.
interface apb_master_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_SLAVES = 2
);
  logic                             i_cmd_valid;
  logic                             o_cmd_ready;
  logic                             i_cmd_write;
  logic [ADDR_WIDTH-1:0]            i_cmd_addr;
  logic [DATA_WIDTH-1:0]            i_cmd_wdata;
  logic                             o_rsp_valid;
  logic [DATA_WIDTH-1:0]            o_rsp_rdata;
  logic                             o_rsp_err;
  logic                             o_rsp_timeout;
  logic [ADDR_WIDTH-1:0]            o_PADDR;
  logic [NUM_SLAVES-1:0]            o_PSEL;
  logic                             o_PENABLE;
  logic                             o_PWRITE;
  logic [DATA_WIDTH-1:0]            o_PWDATA;
  logic [NUM_SLAVES-1:0]            i_PREADY;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_PRDATA;
  logic [NUM_SLAVES-1:0]            i_PSLVERR;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    input  i_PREADY, i_PRDATA, i_PSLVERR,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    output i_PREADY, i_PRDATA, i_PSLVERR,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA
  );
endinterface

// File: rtl/apb_master_engine.sv
// Single-command APB master: decodes the slave from the top address bits, runs SETUP/ACCESS,
// and reports read data, PSLVERR/decode error and ACCESS timeout on a one-cycle response pulse.
module apb_master_engine #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  apb_master_engine_if.master  bus
);
  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic [SEL_BITS-1:0]   cmd_idx_s;
  logic                  pready_sel_s;
  logic                  pslverr_sel_s;
  logic [DATA_WIDTH-1:0] prdata_sel_s;

  // Slave index of the incoming command and the selected slave's return signals.
  always_comb begin
    cmd_idx_s     = (NUM_SLAVES == 1) ? {SEL_BITS{1'b0}} : bus.i_cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
    pready_sel_s  = 1'b0;
    pslverr_sel_s = 1'b0;
    prdata_sel_s  = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      pready_sel_s  = (int'(idx_q) == k) ? bus.i_PREADY[k]  : pready_sel_s;
      pslverr_sel_s = (int'(idx_q) == k) ? bus.i_PSLVERR[k] : pslverr_sel_s;
      prdata_sel_s  = (int'(idx_q) == k) ? bus.i_PRDATA[k*DATA_WIDTH +: DATA_WIDTH] : prdata_sel_s;
    end
  end

  // Next-state, command latch, timeout counter and registered-output decode.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          write_d = bus.i_cmd_write;
          addr_d  = bus.i_cmd_addr;
          wdata_d = bus.i_cmd_wdata;
          idx_d   = cmd_idx_s;
          if (int'(cmd_idx_s) < NUM_SLAVES) begin
            state_d = ST_SETUP;
          end else begin
            state_d       = ST_RESP;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_sel_s) begin
          state_d       = ST_RESP;
          rsp_err_d     = pslverr_sel_s;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!write_q && !pslverr_sel_s) ? prdata_sel_s : {DATA_WIDTH{1'b0}};
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Counter counts wait cycles; hitting the limit aborts this same cycle.
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d       = ST_RESP;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    rsp_valid_d = (state_d == ST_RESP);
    penable_d   = (state_d == ST_ACCESS);
    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = {NUM_SLAVES{1'b0}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      psel_d[k] = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && (int'(idx_d) == k);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      wdata_q       <= {DATA_WIDTH{1'b0}};
      idx_q         <= {SEL_BITS{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      psel_q        <= {NUM_SLAVES{1'b0}};
      penable_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_err     = rsp_err_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
  assign bus.o_PADDR       = addr_q;
  assign bus.o_PSEL        = psel_q;
  assign bus.o_PENABLE     = penable_q;
  assign bus.o_PWRITE      = write_q;
  assign bus.o_PWDATA      = wdata_q;
endmodule
